// File: rtl/v_mem_access_pkg.sv
// Shared sizes, width encodings and FSM states for the vector memory-access stage.
package v_mem_access_pkg;

  localparam int VLEN   = 512;
  localparam int ELEN   = 64;
  localparam int NSLOT  = VLEN / ELEN;
  localparam int MEM_AW = 64;
  localparam int MEM_DW = 64;
  localparam int NLANE  = MEM_DW / 8;

  localparam logic [1:0] W8  = 2'd0;
  localparam logic [1:0] W16 = 2'd1;
  localparam logic [1:0] W32 = 2'd2;
  localparam logic [1:0] W64 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Byte-offset bits that may be non-zero for a naturally aligned element of this width.
  function automatic logic [2:0] lane_keep(input logic [1:0] w);
    case (w)
      W8:      return 3'b111;
      W16:     return 3'b110;
      W32:     return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] eff_width(input logic [2:0] w);
    return w[2] ? W64 : w[1:0];
  endfunction

endpackage

// File: rtl/v_mem_access_lane_align.sv
// Combinational byte-lane steering: load extract + zero/sign extend, store truncate + shift + byte mask.
// No state, zero latency, no flow control.
module v_mem_lane_align
  import v_mem_access_pkg::*;
(
  input  logic [1:0]        width_i,
  input  logic [2:0]        lane_i,
  input  logic              sext_i,
  input  logic [MEM_DW-1:0] rdata_i,
  input  logic [ELEN-1:0]   slot_i,
  output logic [ELEN-1:0]   ld_data_o,
  output logic [MEM_DW-1:0] st_data_o,
  output logic [NLANE-1:0]  st_mask_o
);

  logic [5:0]        sh;
  logic [MEM_DW-1:0] rsh;
  logic [MEM_DW-1:0] st_trunc;
  logic [NLANE-1:0]  mask_base;

  assign sh  = {lane_i, 3'b000};
  assign rsh = rdata_i >> sh;

  always_comb begin
    ld_data_o = '0;
    st_trunc  = '0;
    mask_base = '0;
    case (width_i)
      W8: begin
        ld_data_o = {{56{sext_i & rsh[7]}}, rsh[7:0]};
        st_trunc  = {56'b0, slot_i[7:0]};
        mask_base = 8'h01;
      end
      W16: begin
        ld_data_o = {{48{sext_i & rsh[15]}}, rsh[15:0]};
        st_trunc  = {48'b0, slot_i[15:0]};
        mask_base = 8'h03;
      end
      W32: begin
        ld_data_o = {{32{sext_i & rsh[31]}}, rsh[31:0]};
        st_trunc  = {32'b0, slot_i[31:0]};
        mask_base = 8'h0F;
      end
      default: begin
        ld_data_o = rsh;
        st_trunc  = slot_i;
        mask_base = 8'hFF;
      end
    endcase
  end

  assign st_data_o = st_trunc << sh;
  assign st_mask_o = mask_base << lane_i;

endmodule

// File: rtl/v_mem_access.sv
// Vector load/store sequencer: one 64-bit beat per element, one response per request, one beat outstanding.
// Optional VMEM_ALIGN_CHECK_EN aborts misaligned requests with resp_err; otherwise lanes align down silently.
module v_mem_access
  import v_mem_access_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_ren_i,
  input  logic              req_wen_i,
  input  logic              req_is_vlx_i,
  input  logic              req_is_vsx_i,
  input  logic [MEM_AW-1:0] req_addr_i,
  input  logic [2:0]        req_width_i,
  input  logic [2:0]        req_len_i,
  input  logic              req_sext_i,
  input  logic [VLEN-1:0]   req_wdata_i,
  input  logic [4:0]        req_wb_addr_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [MEM_DW-1:0] mem_wdata_o,
  output logic [NLANE-1:0]  mem_wmask_o,
  input  logic              mem_rvalid_i,
  input  logic [MEM_DW-1:0] mem_rdata_i,
  output logic              resp_valid_o,
  output logic              resp_wb_en_o,
  output logic [4:0]        resp_wb_addr_o,
  output logic [VLEN-1:0]   resp_data_o,
  output logic              resp_err_o
);

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] base_q;
  logic [1:0]        width_q;
  logic [2:0]        len_q, idx_q;
  logic              sext_q, we_q;
  logic [VLEN-1:0]   wdata_q, acc_q;
  logic [4:0]        wb_addr_q;
  logic              err_w;

  logic              accept, plain, last;
  logic [1:0]        width_d;
  logic [MEM_AW-1:0] ea;
  logic [2:0]        lane;
  logic [ELEN-1:0]   slot, ld_data;
  logic [MEM_DW-1:0] st_data;
  logic [NLANE-1:0]  st_mask;

  assign accept  = (state_q == ST_IDLE) & req_valid_i & (req_ren_i | req_wen_i);
  assign plain   = ~req_is_vlx_i & ~req_is_vsx_i;
  assign width_d = plain ? W64 : eff_width(req_width_i);
  assign last    = (idx_q == len_q);
  assign ea      = base_q + (MEM_AW'(idx_q) << width_q);
  assign slot    = wdata_q[{idx_q, 6'b0} +: ELEN];

`ifdef VMEM_ALIGN_CHECK_EN
  logic err_q, align_err;
  assign align_err = |(req_addr_i[2:0] & ~lane_keep(width_d));
  assign lane      = ea[2:0];
  assign err_w     = err_q;
`else
  assign lane      = ea[2:0] & lane_keep(width_q);
  assign err_w     = 1'b0;
`endif

  v_mem_lane_align u_align (
    .width_i   (width_q),
    .lane_i    (lane),
    .sext_i    (sext_q),
    .rdata_i   (mem_rdata_i),
    .slot_i    (slot),
    .ld_data_o (ld_data),
    .st_data_o (st_data),
    .st_mask_o (st_mask)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef VMEM_ALIGN_CHECK_EN
          state_d = align_err ? ST_DONE : ST_REQ;
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (mem_req_ready_i) begin
          if (we_q) state_d = last ? ST_DONE : ST_REQ;
          else      state_d = ST_WAIT_R;
        end
      end
      ST_WAIT_R: if (mem_rvalid_i) state_d = last ? ST_DONE : ST_REQ;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o     = (state_q == ST_IDLE);
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    mem_wmask_o     = '0;
    resp_valid_o    = 1'b0;
    resp_wb_en_o    = 1'b0;
    resp_wb_addr_o  = '0;
    resp_data_o     = '0;
    resp_err_o      = 1'b0;
    if (state_q == ST_REQ) begin
      mem_req_valid_o = 1'b1;
      mem_we_o        = we_q;
      mem_addr_o      = {ea[MEM_AW-1:3], 3'b000};
      if (we_q) begin
        mem_wdata_o = st_data;
        mem_wmask_o = st_mask;
      end
    end
    if (state_q == ST_DONE) begin
      resp_valid_o   = 1'b1;
      resp_wb_en_o   = ~we_q & ~err_w;
      resp_wb_addr_o = wb_addr_q;
      resp_data_o    = (~we_q & ~err_w) ? acc_q : '0;
      resp_err_o     = err_w;
    end
  end

  // Request fields are frozen at acceptance so the decode stage may move on immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q    <= '0;
      width_q   <= W8;
      len_q     <= '0;
      idx_q     <= '0;
      sext_q    <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      acc_q     <= '0;
      wb_addr_q <= '0;
`ifdef VMEM_ALIGN_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else if (accept) begin
      base_q    <= req_addr_i;
      width_q   <= width_d;
      len_q     <= plain ? 3'd7 : req_len_i;
      idx_q     <= '0;
      sext_q    <= plain ? 1'b0 : req_sext_i;
      we_q      <= req_wen_i & ~req_ren_i;
      wdata_q   <= req_wdata_i;
      acc_q     <= '0;
      wb_addr_q <= req_wb_addr_i;
`ifdef VMEM_ALIGN_CHECK_EN
      err_q     <= align_err;
`endif
    end else if (state_q == ST_REQ && mem_req_ready_i && we_q) begin
      if (!last) idx_q <= idx_q + 3'd1;
    end else if (state_q == ST_WAIT_R && mem_rvalid_i) begin
      acc_q[{idx_q, 6'b0} +: ELEN] <= ld_data;
      if (!last) idx_q <= idx_q + 3'd1;
    end
  end

endmodule
